// File: rtl/tcm_pkg.sv
// Shared constants for the tightly coupled memory arbiters.
package tcm_pkg;

    localparam int TCM_ADDR_W  = 14;
    localparam int TCM_DATA_W  = 32;
    localparam int TCM_STRB_W  = TCM_DATA_W / 8;

    // Bit positions inside the registered read-owner vector
    localparam int RD_OWN_AXI  = 0;
    localparam int RD_OWN_CORE = 1;

endpackage

// File: rtl/tcm_starve_cnt.sv
// Saturating count of consecutive lost arbitration cycles; flags starvation at MAX.
module tcm_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lose,
    input  logic win,
    output logic starve
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (win) begin
            wait_q <= '0;
        end else if (lose && (wait_q != W'(MAX))) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign starve = (wait_q == W'(MAX));

endmodule

// File: rtl/tcm_ram_arb.sv
// Data-side TCM arbiter: AXI bridge RAM port and CPU core port share one
// single-port SRAM; core has priority until the bridge has starved STARVE_MAX cycles.
module tcm_ram_arb
    import tcm_pkg::*;
#(
    parameter int ADDR_W     = TCM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [TCM_STRB_W-1:0] axi_ram_wr_i,
    input  logic                  axi_ram_rd_i,
    input  logic [31:0]           axi_ram_addr_i,
    input  logic [31:0]           axi_ram_write_data_i,
    output logic                  axi_ram_accept_o,
    output logic [31:0]           axi_ram_read_data_o,

    input  logic [TCM_STRB_W-1:0] core_wr_i,
    input  logic                  core_rd_i,
    input  logic [31:0]           core_addr_i,
    input  logic [31:0]           core_write_data_i,
    output logic                  core_accept_o,
    output logic                  core_ack_o,
    output logic [31:0]           core_read_data_o,

    output logic                  sram_cs_o,
    output logic [TCM_STRB_W-1:0] sram_we_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    logic req_b;
    logic req_c;
    logic grant_b;
    logic grant_c;
    logic starve;
    logic rd_b;
    logic rd_c;

    logic [1:0]  rd_own_q;
    logic        core_ack_q;
    logic [31:0] core_rdata_q;

    assign req_b = axi_ram_rd_i | (|axi_ram_wr_i);
    assign req_c = core_rd_i | (|core_wr_i);

    // Grants are forced low while reset is held so nothing reaches the SRAM
    assign grant_b = rst_ni & req_b & (~req_c | starve);
    assign grant_c = rst_ni & req_c & ~grant_b;

    assign axi_ram_accept_o = grant_b;
    assign core_accept_o    = grant_c;

    // A write strobe overrides a simultaneous read on the same port
    assign rd_b = grant_b & axi_ram_rd_i & ~(|axi_ram_wr_i);
    assign rd_c = grant_c & core_rd_i & ~(|core_wr_i);

    tcm_starve_cnt #(
        .MAX    (STARVE_MAX)
    ) u_starve (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .lose   (req_b & ~grant_b),
        .win    (grant_b),
        .starve (starve)
    );

    always_comb begin
        sram_cs_o    = grant_b | grant_c;
        sram_we_o    = '0;
        sram_addr_o  = core_addr_i[ADDR_W+1:2];
        sram_wdata_o = core_write_data_i;
        if (grant_b) begin
            sram_we_o    = axi_ram_wr_i;
            sram_addr_o  = axi_ram_addr_i[ADDR_W+1:2];
            sram_wdata_o = axi_ram_write_data_i;
        end else if (grant_c) begin
            sram_we_o    = core_wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_own_q   <= '0;
            core_ack_q <= 1'b0;
        end else begin
            rd_own_q[RD_OWN_CORE] <= rd_c;
            rd_own_q[RD_OWN_AXI]  <= rd_b;
            core_ack_q            <= grant_c;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_rdata_q <= '0;
        end else if (rd_own_q[RD_OWN_CORE]) begin
            core_rdata_q <= sram_rdata_i;
        end
    end

    // The bridge qualifies its read data with its own accept history
    assign axi_ram_read_data_o = sram_rdata_i;
    assign core_read_data_o    = rd_own_q[RD_OWN_CORE] ? sram_rdata_i : core_rdata_q;
    assign core_ack_o          = core_ack_q;

    logic unused_bits;
    assign unused_bits = ^{axi_ram_addr_i[31:ADDR_W+2], axi_ram_addr_i[1:0],
                           core_addr_i[31:ADDR_W+2], core_addr_i[1:0],
                           rd_own_q[RD_OWN_AXI]};

endmodule

// File: tb/tb_tcm_ram_arb.sv
// Bench for tcm_ram_arb: directed scenarios plus random traffic against a
// transaction-level model of priority, starvation and memory contents.
module tb_tcm_ram_arb;

    localparam int AW    = 14;
    localparam int SMAX  = 4;
    localparam int WORDS = 1 << AW;

    logic        clk;
    logic        rst_ni;
    logic [3:0]  b_wr;
    logic        b_rd;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_acc;
    logic [31:0] b_rdata;
    logic [3:0]  c_wr;
    logic        c_rd;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_acc;
    logic        c_ack;
    logic [31:0] c_rdata;
    logic        cs;
    logic [3:0]  we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    tcm_ram_arb #(
        .ADDR_W     (AW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .axi_ram_wr_i         (b_wr),
        .axi_ram_rd_i         (b_rd),
        .axi_ram_addr_i       (b_addr),
        .axi_ram_write_data_i (b_wdata),
        .axi_ram_accept_o     (b_acc),
        .axi_ram_read_data_o  (b_rdata),
        .core_wr_i            (c_wr),
        .core_rd_i            (c_rd),
        .core_addr_i          (c_addr),
        .core_write_data_i    (c_wdata),
        .core_accept_o        (c_acc),
        .core_ack_o           (c_ack),
        .core_read_data_o     (c_rdata),
        .sram_cs_o            (cs),
        .sram_we_o            (we),
        .sram_addr_o          (addr),
        .sram_wdata_o         (wdata),
        .sram_rdata_i         (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: byte writes, registered read data
    logic [31:0] sram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (cs) begin
            if (we == 4'b0000) begin
                rdata <= sram_mem[addr];
            end else begin
                if (we[0]) sram_mem[addr][7:0]   <= wdata[7:0];
                if (we[1]) sram_mem[addr][15:8]  <= wdata[15:8];
                if (we[2]) sram_mem[addr][23:16] <= wdata[23:16];
                if (we[3]) sram_mem[addr][31:24] <= wdata[31:24];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    int          losses;
    logic [31:0] exp_hold;
    logic        last_gb;
    int          checks;
    int          failures;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        sram_mem[w] = v;
        ref_mem[w]  = v;
    endtask

    task automatic set_in(input logic [3:0] bw, input logic br, input logic [31:0] ba,
                          input logic [31:0] bd, input logic [3:0] cw, input logic cr,
                          input logic [31:0] ca, input logic [31:0] cd);
        b_wr = bw; b_rd = br; b_addr = ba; b_wdata = bd;
        c_wr = cw; c_rd = cr; c_addr = ca; c_wdata = cd;
    endtask

    task automatic idle_in();
        set_in(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // One model-checked cycle; inputs must already be applied.
    task automatic step();
        logic rb, rc, gb, gc, nb_rd, nc_rd;
        logic [31:0] exp_b;
        int w;
        @(negedge clk);
        rb = b_rd || (b_wr != 4'h0);
        rc = c_rd || (c_wr != 4'h0);
        gb = rb && (!rc || losses >= SMAX);
        gc = rc && !gb;
        check_eq("axi_accept", 32'(b_acc), 32'(gb));
        check_eq("core_accept", 32'(c_acc), 32'(gc));
        check_eq("sram_cs", 32'(cs), 32'(gb || gc));
        exp_b = 32'h0;
        nb_rd = 1'b0;
        nc_rd = 1'b0;
        if (gb || gc) begin
            w = gb ? word_of(b_addr) : word_of(c_addr);
            check_eq("sram_addr", 32'(addr), 32'(w));
            check_eq("sram_we", 32'(we), 32'(gb ? b_wr : c_wr));
            check_eq("sram_wdata", wdata, gb ? b_wdata : c_wdata);
            nb_rd = gb && (b_wr == 4'h0);
            nc_rd = gc && (c_wr == 4'h0);
            if (nb_rd) exp_b = ref_mem[w];
            if (nc_rd) exp_hold = ref_mem[w];
            if (gb && b_wr != 4'h0) ref_mem[w] = merge(ref_mem[w], b_wdata, b_wr);
            if (gc && c_wr != 4'h0) ref_mem[w] = merge(ref_mem[w], c_wdata, c_wr);
        end
        if (gb) losses = 0;
        else if (rb && losses < SMAX) losses++;
        last_gb = gb;
        @(posedge clk);
        #1;
        check_eq("core_ack", 32'(c_ack), 32'(gc));
        check_eq("core_rdata", c_rdata, exp_hold);
        if (nb_rd) check_eq("axi_rdata", b_rdata, exp_b);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [11:0] bmask;
        checks   = 0;
        failures = 0;
        losses   = 0;
        exp_hold = 32'h0;
        last_gb  = 1'b0;
        for (int i = 0; i < WORDS; i++) preload(i, 32'h0);
        rdata = 32'h0;

        // Reset with both ports requesting
        rst_ni = 1'b0;
        set_in(4'h0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1, 32'h4, 32'h0);
        @(negedge clk);
        check_eq("rst_axi_accept", 32'(b_acc), 32'h0);
        check_eq("rst_core_accept", 32'(c_acc), 32'h0);
        check_eq("rst_cs", 32'(cs), 32'h0);
        check_eq("rst_ack", 32'(c_ack), 32'h0);
        check_eq("rst_core_rdata", c_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle_in();

        // Bridge-only read of word 4
        preload(4, 32'hDEADBEEF);
        set_in(4'h0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("t1_axi_rdata", b_rdata, 32'hDEADBEEF);
        check_eq("t1_no_ack", 32'(c_ack), 32'h0);
        idle_in();
        step();

        // Core partial write then read-back
        set_in(4'h0, 1'b0, 32'h0, 32'h0, 4'b0011, 1'b0, 32'h0000_0020, 32'h12345678);
        step();
        set_in(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0020, 32'h0);
        step();
        check_eq("t2_core_rdata", c_rdata, 32'h00005678);
        idle_in();
        for (int i = 0; i < 10; i++) step();
        check_eq("t2_core_hold", c_rdata, 32'h00005678);

        // Contention with simultaneous reads of distinct words
        preload(1, 32'hA);
        preload(2, 32'hB);
        bmask = '0;
        set_in(4'h0, 1'b1, 32'h0000_0008, 32'h0, 4'h0, 1'b1, 32'h0000_0004, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step();
            bmask[i] = last_gb;
            if (last_gb) check_eq("t3_axi_data", b_rdata, 32'hB);
            else         check_eq("t3_core_data", c_rdata, 32'hA);
        end
        check_eq("t3_bridge_slots", 32'(bmask), 32'h210);
        idle_in();
        step();

        // Address aliasing above the SRAM range
        set_in(4'hF, 1'b0, 32'h0001_0004, 32'hCAFE0001, 4'h0, 1'b0, 32'h0, 32'h0);
        step();
        set_in(4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_0004, 32'h0);
        step();
        check_eq("t4_alias", c_rdata, 32'hCAFE0001);
        idle_in();
        step();

        // Reset right after an accepted core read
        set_in(4'h0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1, 32'h0000_0004, 32'h0);
        @(negedge clk);
        check_eq("t5_core_accept", 32'(c_acc), 32'h1);
        @(posedge clk);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_ack", 32'(c_ack), 32'h0);
        check_eq("t5_core_rdata", c_rdata, 32'h0);
        @(negedge clk);
        check_eq("t5_axi_accept", 32'(b_acc), 32'h0);
        check_eq("t5_core_accept_rst", 32'(c_acc), 32'h0);
        check_eq("t5_cs", 32'(cs), 32'h0);
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        losses   = 0;
        exp_hold = 32'h0;
        idle_in();
        step();
        check_eq("t5_ack_after", 32'(c_ack), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            b_wr    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            b_rd    = 1'($urandom_range(0, 1));
            b_addr  = rand_addr();
            b_wdata = $urandom;
            c_wr    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            c_rd    = ($urandom_range(0, 3) != 0);
            c_addr  = rand_addr();
            c_wdata = $urandom;
            step();
        end
        idle_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
